// File: rtl/instr_replay_pkg.sv
// Shared types and defaults for the instruction replay scheduler.
// The state encoding is shared by the scheduler FSM and the bench.
package instr_replay_pkg;
  localparam int INSTRUCTION_WIDTH_DEF = 50;
  localparam int MAX_INSTRUCTIONS_DEF  = 512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_NEXT_PASS,
    S_FETCH,
    S_LOAD,
    S_PRESENT,
    S_DONE,
    S_ERROR
  } state_e;

  // Count needs one extra bit so that a full buffer is representable.
  typedef logic [$clog2(MAX_INSTRUCTIONS_DEF):0]   count_t;
  typedef logic [$clog2(MAX_INSTRUCTIONS_DEF)-1:0] ptr_t;
endpackage

// File: rtl/instr_replay_ram.sv
// Simple dual-port instruction buffer: one write port, one registered read port.
// Deliberately reset-free so it maps onto block RAM.
module instr_replay_ram #(
  parameter  int W     = 50,
  parameter  int DEPTH = 512,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/instr_replay_scheduler.sv
// Pass 0 forwards and records the decoded stream; later passes replay it from
// the buffer so every column slice sees the same command sequence.
module instr_replay_scheduler
  import instr_replay_pkg::*;
#(
  parameter  int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEF,
  parameter  int MAX_INSTRUCTIONS  = MAX_INSTRUCTIONS_DEF,
  parameter  int PASSES            = 2,
  localparam int PW                = $clog2(PASSES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_last,
  output logic                         in_ready,
  input  logic                         in_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] in_data,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [INSTRUCTION_WIDTH-1:0] out_data,
  output logic [PW-1:0]                pass_index,
  output logic                         done,
  output logic                         overflow
);
  localparam int AW = $clog2(MAX_INSTRUCTIONS);
  localparam int CW = AW + 1;

  state_e                       state_q, state_d;
  logic [CW-1:0]                wr_count_q, wr_count_d;
  logic [CW-1:0]                total_q, total_d;
  logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]                pass_q, pass_d, pass_nxt;
  logic [INSTRUCTION_WIDTH-1:0] out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic                         we, re, cap_ovf;
  logic [INSTRUCTION_WIDTH-1:0] rdata;

  instr_replay_ram #(
    .W     (INSTRUCTION_WIDTH),
    .DEPTH (MAX_INSTRUCTIONS)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_count_q[AW-1:0]),
    .wdata_i (in_data),
    .re_i    (re),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_count_q  <= '0;
      total_q     <= '0;
      rd_ptr_q    <= '0;
      pass_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_count_q  <= wr_count_d;
      total_q     <= total_d;
      rd_ptr_q    <= rd_ptr_d;
      pass_q      <= pass_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign pass_nxt = pass_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    wr_count_d  = wr_count_q;
    total_d     = total_q;
    rd_ptr_d    = rd_ptr_q;
    pass_d      = pass_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    we          = 1'b0;
    re          = 1'b0;
    cap_ovf     = 1'b0;
    in_ready    = 1'b0;
    out_valid   = out_valid_q;
    out_data    = out_data_q;
    out_last    = out_last_q;

    unique case (state_q)
      S_IDLE: state_d = S_CAPTURE;

      S_CAPTURE: begin
        // A beat arriving with the buffer already full is refused outright.
        cap_ovf   = in_valid && (wr_count_q == CW'(MAX_INSTRUCTIONS));
        out_valid = in_valid && !cap_ovf;
        out_data  = in_data;
        out_last  = in_last;
        in_ready  = out_ready && !cap_ovf;
        if (cap_ovf) begin
          state_d = S_ERROR;
        end else if (in_valid && out_ready) begin
          we         = 1'b1;
          wr_count_d = wr_count_q + 1'b1;
          if (in_last) begin
            total_d = wr_count_q + 1'b1;
            state_d = S_NEXT_PASS;
          end
        end
      end

      S_NEXT_PASS: begin
        pass_d = pass_nxt;
        if (pass_nxt == PW'(PASSES)) begin
          state_d = S_DONE;
        end else begin
          rd_ptr_d = '0;
          state_d  = S_FETCH;
        end
      end

      S_FETCH: begin
        re      = 1'b1;
        state_d = S_LOAD;
      end

      S_LOAD: begin
        out_data_d  = rdata;
        out_last_d  = ({1'b0, rd_ptr_q} == (total_q - 1'b1));
        out_valid_d = 1'b1;
        state_d     = S_PRESENT;
      end

      S_PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          state_d     = out_last_q ? S_NEXT_PASS : S_FETCH;
        end
      end

      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
    endcase
  end

  assign pass_index = pass_q;
  assign done       = (state_q == S_DONE);
  assign overflow   = (state_q == S_ERROR);
endmodule

// File: tb/tb_instr_replay_scheduler.sv
// Directed bench: dut 0 (depth 4, 2 passes) and dut 1 (depth 4, 3 passes).
module tb_instr_replay_scheduler;
  localparam int W = 50;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       iv = '0, il = '0;
  logic [1:0][W-1:0] id = '0;
  logic             rnd = 1'b0, ordy_rnd = 1'b1;
  wire  [1:0]       ordy;
  wire  [1:0]       ir, ov, ol, dn, of;
  wire  [1:0][W-1:0] od;
  wire  [1:0][1:0]  pi;

  int nvec = 0, nerr = 0, stab_bad = 0;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_d = '0;
  logic [63:0]  got0[$], got1[$], exp_q[$];

  assign ordy[0] = rnd ? ordy_rnd : 1'b1;
  assign ordy[1] = 1'b1;

  always #5 clk = ~clk;

  instr_replay_scheduler #(.INSTRUCTION_WIDTH(W), .MAX_INSTRUCTIONS(4), .PASSES(2)) u_dut0 (
    .clk(clk), .reset(reset), .in_last(il[0]), .in_ready(ir[0]), .in_valid(iv[0]),
    .in_data(id[0]), .out_last(ol[0]), .out_ready(ordy[0]), .out_valid(ov[0]),
    .out_data(od[0]), .pass_index(pi[0]), .done(dn[0]), .overflow(of[0]));

  instr_replay_scheduler #(.INSTRUCTION_WIDTH(W), .MAX_INSTRUCTIONS(4), .PASSES(3)) u_dut1 (
    .clk(clk), .reset(reset), .in_last(il[1]), .in_ready(ir[1]), .in_valid(iv[1]),
    .in_data(id[1]), .out_last(ol[1]), .out_ready(ordy[1]), .out_valid(ov[1]),
    .out_data(od[1]), .pass_index(pi[1]), .done(dn[1]), .overflow(of[1]));

  function automatic logic [63:0] ent(input logic [1:0] p, input logic l, input logic [W-1:0] d);
    return {11'd0, p, l, d};
  endfunction

  // Collect every downstream handshake; watch dut 0 data stability under stall.
  always @(negedge clk) begin
    if (reset) begin
      got0.delete();
      got1.delete();
      hold_v <= 1'b0;
    end else begin
      if (ov[0] && ordy[0]) got0.push_back(ent(pi[0], ol[0], od[0]));
      if (ov[1] && ordy[1]) got1.push_back(ent(pi[1], ol[1], od[1]));
      if (hold_v && ov[0] && (od[0] !== hold_d)) stab_bad <= stab_bad + 1;
      hold_v <= ov[0] && !ordy[0];
      hold_d <= od[0];
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      ordy_rnd = 1'($urandom & 1);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rst_all();
    reset = 1'b1; iv = '0; il = '0; rnd = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(ir[0]), 0);
    chk("rst_out_valid", 64'(ov[0]), 0);
    chk("rst_out_last", 64'(ol[0]), 0);
    chk("rst_out_data", 64'(od[0]), 0);
    chk("rst_pass_idx", 64'(pi[0]), 0);
    chk("rst_done_ovf", 64'({dn, of}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send(input int s, input logic [W-1:0] d, input logic l);
    int n = 0;
    iv[s] = 1'b1; id[s] = d; il[s] = l;
    do begin @(negedge clk); n++; end while (!ir[s] && n < 200);
    if (!ir[s]) chk("send_timeout", 64'(ir[s]), 1);
    @(posedge clk); #1;
    iv[s] = 1'b0; il[s] = 1'b0;
  endtask

  task automatic wait_done(input int s);
    int n = 0;
    while (!dn[s] && n < 300) begin @(negedge clk); n++; end
    chk("done", 64'(dn[s]), 1);
  endtask

  task automatic cmp(input int s);
    int sz = (s == 0) ? got0.size() : got1.size();
    chk("beat_count", 64'(sz), 64'(exp_q.size()));
    for (int i = 0; i < sz && i < exp_q.size(); i++)
      chk($sformatf("beat%0d", i), (s == 0) ? got0[i] : got1[i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic abc_expect();
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(ent(2'(p), 1'b0, 50'h0_AAAA_0000_0001));
      exp_q.push_back(ent(2'(p), 1'b0, 50'h1_BBBB_0000_0002));
      exp_q.push_back(ent(2'(p), 1'b1, 50'h2_CCCC_0000_0003));
    end
  endtask

  initial begin
    int n;
    // three-beat stream, downstream always ready
    rst_all();
    @(negedge clk);
    chk("idle_in_ready", 64'(ir[0]), 0);
    send(0, 50'h0_AAAA_0000_0001, 1'b0);
    send(0, 50'h1_BBBB_0000_0002, 1'b0);
    send(0, 50'h2_CCCC_0000_0003, 1'b1);
    wait_done(0);
    abc_expect(); cmp(0);
    chk("abc_ovf", 64'(of[0]), 0);
    chk("abc_pass_idx", 64'(pi[0]), 2);

    // same stream under random downstream stalls
    rst_all();
    rnd = 1'b1;
    send(0, 50'h0_AAAA_0000_0001, 1'b0);
    send(0, 50'h1_BBBB_0000_0002, 1'b0);
    send(0, 50'h2_CCCC_0000_0003, 1'b1);
    wait_done(0);
    rnd = 1'b0;
    abc_expect(); cmp(0);
    chk("stall_stable", 64'(stab_bad), 0);

    // single instruction, three passes
    rst_all();
    send(1, 50'h3_DDDD_0000_00D0, 1'b1);
    wait_done(1);
    for (int p = 0; p < 3; p++) exp_q.push_back(ent(2'(p), 1'b1, 50'h3_DDDD_0000_00D0));
    cmp(1);
    chk("single_pass_idx", 64'(pi[1]), 3);

    // exactly full buffer
    rst_all();
    for (int i = 0; i < 4; i++) send(0, 50'(64'h100 + i), i == 3);
    wait_done(0);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) exp_q.push_back(ent(2'(p), i == 3, 50'(64'h100 + i)));
    cmp(0);
    chk("full_ovf", 64'(of[0]), 0);

    // one beat beyond the buffer
    rst_all();
    for (int i = 0; i < 4; i++) send(0, 50'(64'h200 + i), 1'b0);
    iv[0] = 1'b1; id[0] = 50'h2FF;
    @(negedge clk);
    chk("ovf_in_ready", 64'(ir[0]), 0);
    chk("ovf_out_valid", 64'(ov[0]), 0);
    @(negedge clk);
    chk("ovf_flag", 64'(of[0]), 1);
    chk("ovf_done", 64'(dn[0]), 0);
    chk("ovf_in_ready2", 64'(ir[0]), 0);
    iv[0] = 1'b0;

    // reset in the middle of the replay pass
    rst_all();
    send(0, 50'h5_0000_0000_0050, 1'b0);
    send(0, 50'h5_0000_0000_0051, 1'b1);
    n = 0;
    while (got0.size() < 3 && n < 200) begin @(negedge clk); n++; end
    chk("mid_beats", 64'(got0.size()), 3);
    chk("mid_pass_idx", 64'(pi[0]), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_pass_idx", 64'(pi[0]), 0);
    chk("mid_rst_out_valid", 64'(ov[0]), 0);
    chk("mid_rst_out_data", 64'(od[0]), 0);
    rst_all();
    send(0, 50'h6_0000_0000_0060, 1'b0);
    send(0, 50'h6_0000_0000_0061, 1'b1);
    wait_done(0);
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(ent(2'(p), 1'b0, 50'h6_0000_0000_0060));
      exp_q.push_back(ent(2'(p), 1'b1, 50'h6_0000_0000_0061));
    end
    cmp(0);

    // upstream keeps pushing after done
    iv[0] = 1'b1; id[0] = 50'h7_7777; il[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_done_in_ready", 64'(ir[0]), 0);
      chk("post_done_out_valid", 64'(ov[0]), 0);
    end
    iv[0] = 1'b0; il[0] = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
